// File: rtl/gbc_oam_dma_ctrl_pkg.sv
// Shared types and constants for the OAM DMA sequencer.
// State encoding, default OAM base and the echo-RAM fold helper.
package gbc_oam_dma_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_COPY  = 2'd2,
    ST_LAST  = 2'd3
  } dma_state_e;

  localparam logic [14:0] DST_BASE_DEF = 15'h7E00;
  localparam logic [7:0]  ECHO_FOLD    = 8'hE0;

  // Pages E0..FF alias C0..DF.
  function automatic logic [7:0] fold_page(input logic [7:0] hi);
    return (hi >= ECHO_FOLD) ? hi - 8'h20 : hi;
  endfunction

endpackage

// File: rtl/dma_byte_counter.sv
// 9-bit loadable byte index for the OAM DMA copy loop.
// Terminal count flags the last byte of the transfer.
module dma_byte_counter #(
  parameter int LEN = 160
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [8:0] k_o,
  output logic       tc_o
);

  logic [8:0] k_q, k_d;

  always_comb begin
    k_d = k_q;
    if (clr_i)
      k_d = '0;
    else if (inc_i)
      k_d = k_q + 9'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      k_q <= '0;
    else
      k_q <= k_d;
  end

  assign k_o  = k_q;
  assign tc_o = (k_q == 9'(LEN - 1));

endmodule

// File: rtl/gbc_oam_dma_ctrl.sv
// OAM DMA sequencer: reads a source page on BRAM port A and
// writes OAM through port B, arbitrating port A with the CPU.
module gbc_oam_dma_ctrl
  import gbc_oam_dma_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 15,
  parameter int                XFER_LEN    = 160,
  parameter logic [ADDR_W-1:0] DST_BASE    = ADDR_W'(DST_BASE_DEF),
  parameter int                START_DELAY = 1
) (
  input  logic              I_CLK,
  input  logic              I_RESET_N,
  input  logic              I_START,
  input  logic [7:0]        I_SRC_HI,
  input  logic              I_CPU_EN,
  input  logic              I_CPU_WE,
  input  logic [ADDR_W-1:0] I_CPU_ADDR,
  input  logic [7:0]        I_CPU_DIN,
  output logic [7:0]        O_CPU_DOUT,
  output logic              O_CPU_BUSY,
  output logic              O_MA_EN,
  output logic              O_MA_WE,
  output logic [ADDR_W-1:0] O_MA_ADDR,
  output logic [7:0]        O_MA_DIN,
  input  logic [7:0]        I_MA_DOUT,
  output logic              O_MB_EN,
  output logic              O_MB_WE,
  output logic [ADDR_W-1:0] O_MB_ADDR,
  output logic [7:0]        O_MB_DIN,
  output logic              O_DMA_ACTIVE,
  output logic              O_DONE
);

  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0] DLY_END = DW'(START_DELAY - 1);

  dma_state_e        state_q, state_d;
  logic [7:0]        src_q, src_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic              grant_q;
  logic              k_clr, k_inc;
  logic [8:0]        k;
  logic              tc;
  logic              busy;
  logic [15:0]       rd_full;
  logic [ADDR_W-1:0] rd_addr;

  dma_byte_counter #(
    .LEN (XFER_LEN)
  ) u_cnt (
    .clk_i  (I_CLK),
    .rst_ni (I_RESET_N),
    .clr_i  (k_clr),
    .inc_i  (k_inc),
    .k_o    (k),
    .tc_o   (tc)
  );

  assign busy    = (state_q == ST_COPY);
  // No carry into the page byte: the source never leaves its page.
  assign rd_full = {src_q, k[7:0]};
  assign rd_addr = ADDR_W'(rd_full);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dly_d   = dly_q;
    wr_d    = 1'b0;
    wa_d    = wa_q;
    k_clr   = 1'b0;
    k_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_DELAY: begin
        if (dly_q == DLY_END) begin
          state_d = ST_COPY;
          k_clr   = 1'b1;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_COPY: begin
        wr_d = 1'b1;
        wa_d = DST_BASE + ADDR_W'(k);
        if (tc)
          state_d = ST_LAST;
        else
          k_inc = 1'b1;
      end
      ST_LAST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A start in any state (re)arms the transfer; a pending write still lands.
    if (I_START) begin
      state_d = ST_DELAY;
      src_d   = fold_page(I_SRC_HI);
      dly_d   = '0;
      k_clr   = 1'b1;
      k_inc   = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dly_q   <= '0;
      wr_q    <= 1'b0;
      wa_q    <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dly_q   <= dly_d;
      wr_q    <= wr_d;
      wa_q    <= wa_d;
      grant_q <= I_CPU_EN & ~busy & ~I_CPU_WE;
    end
  end

  always_comb begin
    O_MA_EN   = I_CPU_EN;
    O_MA_WE   = I_CPU_WE;
    O_MA_ADDR = I_CPU_ADDR;
    O_MA_DIN  = I_CPU_DIN;
    if (busy) begin
      O_MA_EN   = 1'b1;
      O_MA_WE   = 1'b0;
      O_MA_ADDR = rd_addr;
      O_MA_DIN  = '0;
    end
  end

  assign O_MB_EN      = wr_q;
  assign O_MB_WE      = wr_q;
  assign O_MB_ADDR    = wr_q ? wa_q : '0;
  assign O_MB_DIN     = wr_q ? I_MA_DOUT : 8'h00;
  assign O_CPU_DOUT   = grant_q ? I_MA_DOUT : 8'hFF;
  assign O_CPU_BUSY   = busy;
  assign O_DMA_ACTIVE = (state_q != ST_IDLE);
  assign O_DONE       = (state_q == ST_LAST);

endmodule

// File: tb/tb_gbc_oam_dma_ctrl.sv
// Bench for gbc_oam_dma_ctrl with a behavioural dual-port BRAM
// and a scoreboard of expected OAM writes.
module tb_gbc_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  src_hi;
  logic        cpu_en, cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        busy;
  logic        ma_en, ma_we;
  logic [14:0] ma_addr;
  logic [7:0]  ma_din;
  logic [7:0]  ma_dout;
  logic        mb_en, mb_we;
  logic [14:0] mb_addr;
  logic [7:0]  mb_din;
  logic        active, done;

  logic        init;
  logic [7:0]  mem [0:32767];
  logic [7:0]  old [0:159];
  logic [31:0] sb [$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  gbc_oam_dma_ctrl dut (
    .I_CLK        (clk),
    .I_RESET_N    (rst_n),
    .I_START      (start),
    .I_SRC_HI     (src_hi),
    .I_CPU_EN     (cpu_en),
    .I_CPU_WE     (cpu_we),
    .I_CPU_ADDR   (cpu_addr),
    .I_CPU_DIN    (cpu_din),
    .O_CPU_DOUT   (cpu_dout),
    .O_CPU_BUSY   (busy),
    .O_MA_EN      (ma_en),
    .O_MA_WE      (ma_we),
    .O_MA_ADDR    (ma_addr),
    .O_MA_DIN     (ma_din),
    .I_MA_DOUT    (ma_dout),
    .O_MB_EN      (mb_en),
    .O_MB_WE      (mb_we),
    .O_MB_ADDR    (mb_addr),
    .O_MB_DIN     (mb_din),
    .O_DMA_ACTIVE (active),
    .O_DONE       (done)
  );

  function automatic logic [7:0] pat(input logic [14:0] a);
    if (a == 15'h1000) return 8'h11;
    if (a == 15'h0100) return 8'hA5;
    if (a[14:8] == 7'h40) return a[7:0] ^ 8'h5A;
    if (a[14:8] == 7'h60) return 8'(a[7:0] * 8'd3);
    if (a[14:8] == 7'h30) return a[7:0] ^ 8'hC3;
    if (a[14:8] == 7'h41) return ~a[7:0];
    if (a[14:8] == 7'h50) return a[7:0] + 8'd7;
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  always @(posedge clk) begin
    if (init) begin
      for (int a = 0; a < 32768; a++)
        mem[a] <= pat(15'(a));
    end else begin
      if (ma_en) begin
        if (ma_we)
          mem[ma_addr] <= ma_din;
        ma_dout <= mem[ma_addr];
      end
      if (mb_en && mb_we)
        mem[mb_addr] <= mb_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done)
      done_cnt++;
    if (mb_en && mb_we) begin
      if (sb.size() == 0)
        chk("sb_extra", {9'd0, mb_addr, mb_din}, 32'hFFFF_FFFF);
      else
        chk("oam_wr", {9'd0, mb_addr, mb_din}, sb.pop_front());
    end
  end

  task automatic push_run(input logic [14:0] src, input int n);
    for (int i = 0; i < n; i++)
      sb.push_back({9'd0, 15'h7E00 + 15'(i), pat(src + 15'(i))});
  endtask

  task automatic pulse_start(input logic [7:0] hi);
    @(negedge clk);
    start  = 1'b1;
    src_hi = hi;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_k(input int k);
    int  n;
    logic hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hit = busy && (ma_addr[7:0] == k[7:0]);
    end while (!hit && n < 600);
    chk("wait_k", 32'(hit), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (active && n < 600);
    chk("wait_idle", 32'(active), 32'd0);
  endtask

  task automatic chk_oam(input string tag, input logic [14:0] src,
                         input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      chk(tag, 32'(mem[15'h7E00 + 15'(i)]), 32'(pat(src + 15'(i))));
  endtask

  initial begin
    int act_n, done_at, first_rd, d0;
    rst_n    = 1'b0;
    init     = 1'b1;
    start    = 1'b0;
    src_hi   = 8'h00;
    cpu_en   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 15'h0ABC;
    cpu_din  = 8'h00;
    @(negedge clk);
    init = 1'b0;
    #1;
    chk("rst_ma_addr", 32'(ma_addr), 32'h0ABC);
    chk("rst_ma_en", 32'(ma_en), 32'd1);
    chk("rst_mb", {mb_en, mb_we, mb_din, 7'd0, mb_addr}, 32'd0);
    chk("rst_flags", {busy, active, done}, 32'd0);
    chk("rst_dout", 32'(cpu_dout), 32'hFF);
    cpu_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Plain 160-byte copy from page 40
    push_run(15'h4000, 160);
    @(negedge clk);
    start  = 1'b1;
    src_hi = 8'h40;
    @(posedge clk);
    act_n = 0;
    done_at = 0;
    first_rd = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (active) act_n++;
      if (done && done_at == 0) done_at = n;
      if (busy && first_rd == 0) first_rd = n;
    end
    chk("t1_active", act_n, 162);
    chk("t1_done", done_at, 162);
    chk("t1_first_rd", first_rd, 2);
    chk("t1_sb", sb.size(), 0);
    chk_oam("t1_mem", 15'h4000, 0, 160);

    // CPU contention during COPY
    push_run(15'h6000, 160);
    pulse_start(8'h60);
    wait_k(10);
    cpu_en   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 15'h1234;
    #1;
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_ma_addr", 32'(ma_addr), 32'h600A);
    chk("t2_ma_we", 32'(ma_we), 32'd0);
    @(negedge clk);
    cpu_en = 1'b0;
    chk("t2_dout", 32'(cpu_dout), 32'hFF);
    wait_k(20);
    cpu_en   = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 15'h1000;
    cpu_din  = 8'h77;
    #1;
    chk("t2_wr_blk", 32'(ma_we), 32'd0);
    @(negedge clk);
    cpu_en = 1'b0;
    cpu_we = 1'b0;
    wait_idle();
    chk("t2_mem_keep", 32'(mem[15'h1000]), 32'h11);
    chk("t2_sb", sb.size(), 0);

    // Restart mid-copy: the write of byte 49 lands in DELAY
    d0 = done_cnt;
    push_run(15'h4000, 50);
    push_run(15'h5000, 160);
    pulse_start(8'h40);
    wait_k(49);
    start  = 1'b1;
    src_hi = 8'h50;
    @(negedge clk);
    start = 1'b0;
    chk("t3_delay", {active, busy, mb_en}, 3'b101);
    wait_idle();
    chk("t3_done_once", done_cnt - d0, 1);
    chk("t3_sb", sb.size(), 0);
    chk_oam("t3_mem", 15'h5000, 0, 160);

    // Async reset mid-copy
    for (int i = 0; i < 160; i++)
      old[i] = mem[15'h7E00 + 15'(i)];
    push_run(15'h3000, 80);
    pulse_start(8'h30);
    wait_k(80);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_mb_en", 32'(mb_en), 32'd0);
    chk("t4_flags", {active, busy, done}, 32'd0);
    chk("t4_dout", 32'(cpu_dout), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_sb", sb.size(), 0);
    chk_oam("t4_new", 15'h3000, 0, 79);
    for (int i = 80; i < 160; i++)
      chk("t4_old", 32'(mem[15'h7E00 + 15'(i)]), 32'(old[i]));

    // Echo fold: E1 -> C1, truncated to 0x4100
    push_run(15'h4100, 160);
    pulse_start(8'hE1);
    wait_k(0);
    chk("t5_rd_addr", 32'(ma_addr), 32'h4100);
    wait_idle();
    chk("t5_sb", sb.size(), 0);

    // DF is below the fold boundary
    push_run(15'h5F00, 160);
    pulse_start(8'hDF);
    wait_k(0);
    chk("t5_df_addr", 32'(ma_addr), 32'h5F00);
    wait_idle();
    chk("t5_df_sb", sb.size(), 0);

    // Idle CPU pass-through
    @(negedge clk);
    cpu_en   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 15'h0100;
    #1;
    chk("t6_ma_addr", 32'(ma_addr), 32'h0100);
    chk("t6_ma_en", {ma_en, ma_we, busy}, 3'b100);
    @(negedge clk);
    chk("t6_rd", 32'(cpu_dout), 32'hA5);
    cpu_we   = 1'b1;
    cpu_addr = 15'h0200;
    cpu_din  = 8'h3C;
    #1;
    chk("t6_we", {ma_en, ma_we}, 2'b11);
    @(negedge clk);
    cpu_we = 1'b0;
    @(negedge clk);
    cpu_en = 1'b0;
    chk("t6_rdback", 32'(cpu_dout), 32'h3C);
    @(negedge clk);
    chk("t6_noreq", 32'(cpu_dout), 32'hFF);
    chk("t6_mem", 32'(mem[15'h0200]), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
